fp_sub_seq: RTL and testbench

Multi-cycle IEEE-754 single-precision subtractor computing `result = A - B`. It is the subtract-direction counterpart of the combinational FP adder. Unlike the adder, it restores the hidden bit, swaps operands by magnitude, aligns and normalises one bit per clock, and handles zero, NaN/Inf, overflow and underflow. It sits on the datapath behind a start/done handshake, so long-latency subtracts do not close timing through a single combinational cone.

---
 rtl/fp_sub_seq.sv | 150 +++++++++++++++
 tb/tb_fp_sub_seq.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/fp_sub_seq.sv
// Multi-cycle IEEE-754 single-precision subtractor (result = A - B).
// Operands are swapped by magnitude, aligned and normalised one bit per clock.
module fp_sub_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [2:0] {IDLE, ALIGN, ADDSUB, NORM, DONE} state_t;

  state_t      state_q;
  logic        busy_q, done_q;
  logic [31:0] result_q;
  logic [24:0] ml_q, ms_q;
  logic [7:0]  exp_q, d_q;
  logic        sign_q, add_q, nan_q;

  logic [7:0]  ea, eb;
  logic [23:0] ma, mb;
  logic        a_big;
  logic [24:0] ml_d, ms_d;
  logic [7:0]  exp_d, d_d;
  logic        sign_d, add_d, nan_d;

  function automatic logic [31:0] sat_inf(input logic s);
    return {s, 8'hFF, 23'h0};
  endfunction

  function automatic logic [31:0] flush_zero(input logic s);
    return {s, 31'h0};
  endfunction

  function automatic logic [31:0] pack(input logic s, input logic [7:0] e,
                                       input logic [22:0] f);
    return {s, e, f};
  endfunction

  // Operand capture: flush denormals, restore hidden bit, order by magnitude.
  always_comb begin
    ea     = A[30:23];
    eb     = B[30:23];
    ma     = (ea == 8'd0) ? 24'd0 : {1'b1, A[22:0]};
    mb     = (eb == 8'd0) ? 24'd0 : {1'b1, B[22:0]};
    a_big  = (ea > eb) || ((ea == eb) && (A[22:0] >= B[22:0]));
    ml_d   = a_big ? {1'b0, ma} : {1'b0, mb};
    ms_d   = a_big ? {1'b0, mb} : {1'b0, ma};
    exp_d  = a_big ? ea : eb;
    d_d    = a_big ? (ea - eb) : (eb - ea);
    sign_d = a_big ? A[31] : ~B[31];
    add_d  = (A[31] == ~B[31]);
    nan_d  = (ea == 8'hFF) || (eb == 8'hFF);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            ml_q    <= ml_d;
            ms_q    <= ms_d;
            exp_q   <= exp_d;
            d_q     <= d_d;
            sign_q  <= sign_d;
            add_q   <= add_d;
            nan_q   <= nan_d;
            busy_q  <= 1'b1;
            state_q <= ALIGN;
          end
        end
        ALIGN: begin
          if (nan_q || (d_q == 8'd0)) begin
            state_q <= ADDSUB;
          end else if (d_q > 8'd24) begin
            ms_q    <= 25'd0;
            state_q <= ADDSUB;
          end else begin
            ms_q <= ms_q >> 1;
            d_q  <= d_q - 8'd1;
            if (d_q == 8'd1) state_q <= ADDSUB;
          end
        end
        ADDSUB: begin
          ml_q    <= add_q ? (ml_q + ms_q) : (ml_q - ms_q);
          state_q <= NORM;
        end
        NORM: begin
          // Result is written only on the transition into DONE.
          if (nan_q) begin
            result_q <= 32'h7FC00000;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end else if (ml_q == 25'd0) begin
            result_q <= 32'h0;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end else if (ml_q[24]) begin
            ml_q     <= ml_q >> 1;
            exp_q    <= exp_q + 8'd1;
            result_q <= (exp_q == 8'd254) ? sat_inf(sign_q)
                                          : pack(sign_q, exp_q + 8'd1, ml_q[23:1]);
            done_q   <= 1'b1;
            state_q  <= DONE;
          end else if (ml_q[23]) begin
            result_q <= pack(sign_q, exp_q, ml_q[22:0]);
            done_q   <= 1'b1;
            state_q  <= DONE;
          end else begin
            ml_q  <= ml_q << 1;
            exp_q <= exp_q - 8'd1;
            if (exp_q == 8'd1) begin
              result_q <= flush_zero(sign_q);
              done_q   <= 1'b1;
              state_q  <= DONE;
            end else if (ml_q[22]) begin
              result_q <= pack(sign_q, exp_q - 8'd1, {ml_q[21:0], 1'b0});
              done_q   <= 1'b1;
              state_q  <= DONE;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_fp_sub_seq.sv
// Bench for fp_sub_seq: arithmetic reference model with a per-cycle compare,
// plus directed vectors carrying hand-computed results and latencies.
module tb_fp_sub_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] A, B;
  logic        busy, done;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  fp_sub_seq dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: exact integer arithmetic on the restored mantissas.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output int lat);
    int     ea, eb, el, es, d, acyc, n, msb, sh;
    longint ma, mb, ml, ms, sum;
    bit     sa, sb, sl, ss, a_big;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    ma = (ea == 0) ? 0 : ((longint'(1) << 23) | longint'(a[22:0]));
    mb = (eb == 0) ? 0 : ((longint'(1) << 23) | longint'(b[22:0]));
    sa = a[31];
    sb = !b[31];
    if (ea == 255 || eb == 255) begin
      r = 32'h7FC00000;
      lat = 3;
      return;
    end
    a_big = (ea > eb) || (ea == eb && a[22:0] >= b[22:0]);
    if (a_big) begin el = ea; ml = ma; sl = sa; es = eb; ms = mb; ss = sb; end
    else       begin el = eb; ml = mb; sl = sb; es = ea; ms = ma; ss = sa; end
    d = el - es;
    acyc = (d >= 1 && d <= 24) ? d : 1;
    ms = ms >> d;
    sum = (sl == ss) ? ml + ms : ml - ms;
    n = 1;
    if (sum == 0) begin
      r = 32'h0;
    end else if (sum >= (longint'(1) << 24)) begin
      if (el + 1 >= 255) r = {sl, 8'hFF, 23'h0};
      else               r = {sl, 8'(el + 1), 23'(sum >> 1)};
    end else begin
      msb = 0;
      for (int i = 0; i < 24; i++) if (sum[i]) msb = i;
      sh = 23 - msb;
      if (sh >= el) begin
        r = {sl, 31'h0};
        n = el;
      end else begin
        r = {sl, 8'(el - sh), 23'(sum << sh)};
        n = (sh > 1) ? sh : 1;
      end
    end
    lat = acyc + n + 1;
  endfunction

  // Cycle-level expectation: countdown from acceptance to the done pulse.
  logic        m_busy = 1'b0, m_done = 1'b0;
  logic [31:0] m_res = 32'h0, m_pend = 32'h0;
  int          m_cnt = 0;

  always @(posedge clk) begin
    int lat;
    if (rst) begin
      m_busy = 1'b0; m_done = 1'b0; m_res = 32'h0; m_cnt = 0;
    end else if (!m_busy) begin
      m_done = 1'b0;
      if (start) begin
        model(A, B, m_pend, lat);
        m_cnt = lat;
        m_busy = 1'b1;
      end
    end else if (m_done) begin
      m_busy = 1'b0;
      m_done = 1'b0;
    end else begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_done = 1'b1;
        m_res = m_pend;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_busy", {31'h0, busy}, {31'h0, m_busy});
      chk("cyc_done", {31'h0, done}, {31'h0, m_done});
      chk("cyc_result", result, m_res);
    end
  end

  task automatic wait_done(input string name, output int lat);
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        lat = k;
        break;
      end
    end
    if (lat < 0) chk({name, "_timeout"}, 32'h0, 32'h1);
  endtask

  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_r, input int exp_l);
    logic [31:0] mr;
    int ml, lat;
    model(a, b, mr, ml);
    chk({name, "_model_res"}, mr, exp_r);
    chk({name, "_model_lat"}, ml, exp_l);
    A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(name, lat);
    chk({name, "_lat"}, lat, exp_l);
    chk({name, "_res"}, result, exp_r);
    @(posedge clk); #1;
  endtask

  initial begin
    int lat, pulses;
    rst = 1'b1; start = 1'b0; A = 32'h0; B = 32'h0;
    @(posedge clk);
    chk_en = 1'b1;
    @(posedge clk); #1;
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_result", result, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("sub3m1",   32'h40400000, 32'h3F800000, 32'h40000000, 3);
    run_op("lshift2",  32'h3F800000, 32'h3F400000, 32'h3E800000, 4);
    run_op("carry",    32'h3F800000, 32'hBF800000, 32'h40000000, 3);
    run_op("equal",    32'h3F800000, 32'h3F800000, 32'h00000000, 3);
    run_op("swap",     32'h3F800000, 32'h40400000, 32'hC0000000, 3);
    run_op("d25",      32'h3F800000, 32'h4C000000, 32'hCC000000, 3);
    run_op("d24",      32'h4B800000, 32'h3F800000, 32'h4B800000, 26);
    run_op("d20",      32'h49800000, 32'h3F800000, 32'h497FFFF0, 22);
    run_op("inf_a",    32'h7F800000, 32'h12345678, 32'h7FC00000, 3);
    run_op("nan_b",    32'h3F800000, 32'h7FC00000, 32'h7FC00000, 3);
    run_op("ovf",      32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 3);
    run_op("unf",      32'h00800000, 32'h00800001, 32'h80000000, 3);

    // start held high through busy and the DONE cycle must be ignored
    A = 32'h40400000; B = 32'h3F800000; start = 1'b1;
    @(posedge clk); #1;
    A = 32'h40A00000; B = 32'h3F800000;
    wait_done("busy_start", lat);
    chk("busy_start_lat", lat, 3);
    chk("busy_start_res", result, 32'h40000000);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("busy_start_idle", {31'h0, busy}, 32'h0);
    chk("busy_start_hold", result, 32'h40000000);

    // reset mid-ALIGN discards the operation
    A = 32'h49800000; B = 32'h3F800000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_busy", {31'h0, busy}, 32'h0);
    chk("midrst_done", {31'h0, done}, 32'h0);
    chk("midrst_result", result, 32'h0);
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) pulses++;
    end
    chk("midrst_no_done", pulses, 0);

    run_op("after_rst", 32'h40400000, 32'h3F800000, 32'h40000000, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
